// File: rtl/comm_demap_pack_if.sv
// Stream-in / FIFO-out bundle for the receive demapper/packer.
// The master side feeds bins and reports FIFO fullness; the slave is the packer.
interface comm_demap_pack_if #(
  parameter int WIDTH  = 11,
  parameter int DOUT_W = 128
);
  logic              valid_i;
  logic [WIDTH-1:0]  ar;
  logic [WIDTH-1:0]  ai;
  logic              ready_o;
  logic              wr_en;
  logic [DOUT_W-1:0] dout;
  logic              full;
  logic              valid_raw;
  logic [5:0]        raw;
  logic              err_ovf;

  modport master (
    output valid_i, ar, ai, full,
    input  ready_o, wr_en, dout, valid_raw, raw, err_ovf
  );

  modport slave (
    input  valid_i, ar, ai, full,
    output ready_o, wr_en, dout, valid_raw, raw, err_ovf
  );
endinterface

// File: rtl/comm_demap_pack.sv
// Receive demapper and bit packer between fft64 and the memory FIFO.
// Bins in [SC_FIRST, SC_LAST] are hard-demapped (BPSK/QPSK/16QAM), packed
// LSB-first into DOUT_W-bit words and written with full backpressure.
// Pipeline: accept edge -> symbol stage (raw/valid_raw) -> append edge -> output word.
module comm_demap_pack #(
  parameter int WIDTH     = 11,
  parameter int NSC       = 64,
  parameter int SC_FIRST  = 0,
  parameter int SC_LAST   = 63,
  parameter int MODTYPE   = 1,
  parameter int QAM_THR   = 256,
  parameter int DOUT_W    = 128,
  parameter int FLUSH_EOF = 0
) (
  input logic              CLK,
  input logic              RST,
  comm_demap_pack_if.slave bus
);

  localparam int SCW  = (NSC > 1) ? $clog2(NSC) : 1;
  localparam int CNTW = $clog2(DOUT_W + 1);

  localparam logic [SCW-1:0]   SC_MAX    = SCW'(NSC - 1);
  localparam logic [SCW-1:0]   SC_END    = SCW'(SC_LAST);
  localparam logic [CNTW-1:0]  WORD_BITS = CNTW'(DOUT_W);
  localparam logic [CNTW-1:0]  SYM_BITS  = CNTW'(MODTYPE);
  localparam logic [WIDTH-1:0] THR       = WIDTH'(QAM_THR);

  logic [SCW-1:0]     sc_cnt;
  logic               valid_raw_r;
  logic [5:0]         raw_r;
  logic               stg_vld;
  logic [MODTYPE-1:0] stg_bits;
  logic               stg_last;
  logic [DOUT_W-1:0]  acc;
  logic [CNTW-1:0]    cnt;
  logic [DOUT_W-1:0]  dout_r;
  logic               pend;
  logic               err_r;

  logic               ready;
  logic               accept;
  logic               keep;
  logic [5:0]         sym_bits;
  logic [CNTW-1:0]    cnt_sum;
  logic [DOUT_W-1:0]  acc_ins;
  logic               completes;
  logic               append;
  logic               move;

  // Magnitude with the most negative code saturated to the largest positive one.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] n;
    n = ~x + WIDTH'(1);
    if (!x[WIDTH-1]) return x;
    if (n[WIDTH-1])  return {1'b0, {(WIDTH-1){1'b1}}};
    return n;
  endfunction

  // A held word on a full FIFO is the only thing that can stall the input.
  assign ready  = ~pend | ~bus.full;
  assign accept = bus.valid_i & ready;
  assign keep   = accept && (int'(sc_cnt) >= SC_FIRST) && (int'(sc_cnt) <= SC_LAST);

  // Hard decisions for the incoming bin.
  always_comb begin
    sym_bits    = '0;
    sym_bits[0] = ~bus.ar[WIDTH-1];
    if (MODTYPE == 2) begin
      sym_bits[1] = ~bus.ai[WIDTH-1];
    end else if (MODTYPE == 4) begin
      sym_bits[1] = mag(bus.ar) < THR;
      sym_bits[2] = ~bus.ai[WIDTH-1];
      sym_bits[3] = mag(bus.ai) < THR;
    end
  end

  // Append the staged symbol; a word-completing symbol waits while the output is blocked.
  always_comb begin
    cnt_sum   = cnt + SYM_BITS;
    acc_ins   = acc | (DOUT_W'(stg_bits) << cnt);
    completes = (cnt_sum == WORD_BITS) || ((FLUSH_EOF != 0) && stg_last);
    append    = stg_vld & (~completes | ready);
    move      = append & completes;
  end

  // Subcarrier index follows every presented bin, dropped or not, to keep frame alignment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sc_cnt <= '0;
    end else if (bus.valid_i) begin
      sc_cnt <= (sc_cnt == SC_MAX) ? '0 : sc_cnt + SCW'(1);
    end
  end

  // Symbol stage: raw is a one-cycle pulse; the stage copy survives until appended.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_raw_r <= 1'b0;
      raw_r       <= '0;
      stg_vld     <= 1'b0;
      stg_bits    <= '0;
      stg_last    <= 1'b0;
    end else begin
      valid_raw_r <= keep;
      raw_r       <= keep ? sym_bits : '0;
      if (keep) begin
        stg_vld  <= 1'b1;
        stg_bits <= sym_bits[MODTYPE-1:0];
        stg_last <= (sc_cnt == SC_END);
      end else if (append) begin
        stg_vld <= 1'b0;
      end
    end
  end

  // Bit accumulator; cleared whenever its contents move to the output register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc <= '0;
      cnt <= '0;
    end else if (append) begin
      if (completes) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= acc_ins;
        cnt <= cnt_sum;
      end
    end
  end

  // Output word register; a new word may replace one being written this cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dout_r <= '0;
      pend   <= 1'b0;
    end else if (move) begin
      dout_r <= acc_ins;
      pend   <= 1'b1;
    end else if (pend && !bus.full) begin
      pend <= 1'b0;
    end
  end

  // Sticky overflow flag for bins presented while stalled.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_r <= 1'b0;
    end else if (bus.valid_i && !ready) begin
      err_r <= 1'b1;
    end
  end

  assign bus.ready_o   = ready;
  assign bus.wr_en     = pend & ~bus.full;
  assign bus.dout      = dout_r;
  assign bus.valid_raw = valid_raw_r;
  assign bus.raw       = raw_r;
  assign bus.err_ovf   = err_r;

endmodule

// File: tb/tb_comm_demap_pack.sv
// Bench for comm_demap_pack: three configurations share one stimulus stream
// (0: BPSK full range, 1: 16QAM bins 6..57 with end-of-frame flush, 2: QPSK full range).
// A behavioural model pushes expected raw symbols and words; a monitor pops and compares.
module tb_comm_demap_pack;

  localparam int MT [3] = '{1, 4, 2};
  localparam int SF [3] = '{0, 6, 0};
  localparam int SL [3] = '{63, 57, 63};
  localparam int FL [3] = '{0, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [10:0] ar = '0;
  logic [10:0] ai = '0;
  logic        full = 1'b0;

  logic         rdy [3];
  logic         wr  [3];
  logic         vr  [3];
  logic         eo  [3];
  logic [127:0] dq  [3];
  logic [5:0]   rq  [3];

  int checks   = 0;
  int failures = 0;

  logic [127:0] word_q [3][$];
  logic [5:0]   raw_q  [3][$];
  logic [127:0] acc_m  [3];
  int           n_m    [3];
  int           sc_m   [3];
  logic         err_m  [3];
  logic [127:0] last_word [3];
  logic [5:0]   last_raw  [3];
  logic [127:0] got_c [$];
  logic [127:0] ref_c [$];

  always #5 clk = ~clk;

  comm_demap_pack_if #(.WIDTH(11), .DOUT_W(128)) if_a ();
  comm_demap_pack_if #(.WIDTH(11), .DOUT_W(128)) if_b ();
  comm_demap_pack_if #(.WIDTH(11), .DOUT_W(128)) if_c ();

  comm_demap_pack #(.MODTYPE(1)) u_a (.CLK(clk), .RST(rst_n), .bus(if_a));
  comm_demap_pack #(.MODTYPE(4), .SC_FIRST(6), .SC_LAST(57), .FLUSH_EOF(1), .QAM_THR(256))
    u_b (.CLK(clk), .RST(rst_n), .bus(if_b));
  comm_demap_pack #(.MODTYPE(2)) u_c (.CLK(clk), .RST(rst_n), .bus(if_c));

  assign if_a.valid_i = valid; assign if_a.ar = ar; assign if_a.ai = ai; assign if_a.full = full;
  assign if_b.valid_i = valid; assign if_b.ar = ar; assign if_b.ai = ai; assign if_b.full = full;
  assign if_c.valid_i = valid; assign if_c.ar = ar; assign if_c.ai = ai; assign if_c.full = full;

  assign rdy[0] = if_a.ready_o; assign wr[0] = if_a.wr_en; assign vr[0] = if_a.valid_raw;
  assign eo[0]  = if_a.err_ovf; assign dq[0] = if_a.dout;  assign rq[0] = if_a.raw;
  assign rdy[1] = if_b.ready_o; assign wr[1] = if_b.wr_en; assign vr[1] = if_b.valid_raw;
  assign eo[1]  = if_b.err_ovf; assign dq[1] = if_b.dout;  assign rq[1] = if_b.raw;
  assign rdy[2] = if_c.ready_o; assign wr[2] = if_c.wr_en; assign vr[2] = if_c.valid_raw;
  assign eo[2]  = if_c.err_ovf; assign dq[2] = if_c.dout;  assign rq[2] = if_c.raw;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decision rules written directly with signed integer arithmetic.
  function automatic logic [5:0] demap(input int mt, input logic signed [10:0] r,
                                       input logic signed [10:0] i);
    int ri, ii, mr, mi;
    logic [5:0] b;
    ri = r; ii = i;
    mr = (ri < 0) ? -ri : ri;
    mi = (ii < 0) ? -ii : ii;
    if (mr > 1023) mr = 1023;
    if (mi > 1023) mi = 1023;
    b = '0;
    b[0] = (ri >= 0);
    if (mt == 2) b[1] = (ii >= 0);
    if (mt == 4) begin
      b[1] = (mr < 256);
      b[2] = (ii >= 0);
      b[3] = (mi < 256);
    end
    return b;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      word_q[k].delete();
      raw_q[k].delete();
      acc_m[k] = '0;
      n_m[k]   = 0;
      sc_m[k]  = 0;
      err_m[k] = 1'b0;
    end
  endtask

  // One presented bin per call, judged with the handshake as seen before the edge.
  task automatic model_step();
    logic [5:0] s;
    for (int k = 0; k < 3; k++) begin
      if (valid) begin
        if (!rdy[k]) begin
          err_m[k] = 1'b1;
        end else if (sc_m[k] >= SF[k] && sc_m[k] <= SL[k]) begin
          s = demap(MT[k], ar, ai);
          raw_q[k].push_back(s);
          for (int b = 0; b < MT[k]; b++) begin
            acc_m[k][n_m[k]] = s[b];
            n_m[k]++;
            if (n_m[k] == 128) begin
              word_q[k].push_back(acc_m[k]);
              acc_m[k] = '0;
              n_m[k] = 0;
            end
          end
          if (FL[k] != 0 && sc_m[k] == SL[k] && n_m[k] > 0) begin
            word_q[k].push_back(acc_m[k]);
            acc_m[k] = '0;
            n_m[k] = 0;
          end
        end
        sc_m[k] = (sc_m[k] + 1) % 64;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [10:0] r, input logic [10:0] i, input logic f);
    @(negedge clk);
    valid = v; ar = r; ai = i; full = f;
    #1;
    model_step();
  endtask

  function automatic logic [10:0] rnd11();
    case ($urandom_range(0, 9))
      0: return 11'h400;
      1: return 11'd256;
      2: return 11'd255;
      3: return 11'(-256);
      4: return 11'(-255);
      default: return 11'($urandom);
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0; valid = 1'b0; full = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_wr_en%0d", k), 128'(wr[k]), 128'd0);
      check($sformatf("rst_dout%0d", k), dq[k], 128'd0);
      check($sformatf("rst_valid_raw%0d", k), 128'(vr[k]), 128'd0);
      check($sformatf("rst_raw%0d", k), 128'(rq[k]), 128'd0);
      check($sformatf("rst_err_ovf%0d", k), 128'(eo[k]), 128'd0);
      check($sformatf("rst_ready%0d", k), 128'(rdy[k]), 128'd1);
      last_word[k] = '0;
      last_raw[k]  = '0;
    end
    model_clear();
    got_c.delete();
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    int left;
    left = word_q[0].size() + word_q[1].size() + word_q[2].size()
         + raw_q[0].size() + raw_q[1].size() + raw_q[2].size();
    while (left != 0 && n < 100) begin
      drive(1'b0, '0, '0, 1'b0);
      n++;
      left = word_q[0].size() + word_q[1].size() + word_q[2].size()
           + raw_q[0].size() + raw_q[1].size() + raw_q[2].size();
    end
    check("drain_pending", 128'(left), 128'd0);
    repeat (3) drive(1'b0, '0, '0, 1'b0);
  endtask

  // Monitor: compare every raw pulse and every FIFO write against the model queues.
  always begin
    logic [127:0] e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (vr[k]) begin
          if (raw_q[k].size() == 0) begin
            check($sformatf("raw_unexpected%0d", k), 128'd1, 128'd0);
          end else begin
            e = 128'(raw_q[k].pop_front());
            check($sformatf("raw%0d", k), 128'(rq[k]), e);
          end
          last_raw[k] = rq[k];
        end
        if (wr[k]) begin
          if (word_q[k].size() == 0) begin
            check($sformatf("word_unexpected%0d", k), 128'd1, 128'd0);
          end else begin
            e = word_q[k].pop_front();
            check($sformatf("word%0d", k), dq[k], e);
          end
          last_word[k] = dq[k];
          if (k == 2) got_c.push_back(dq[k]);
        end
      end
    end
  end

  logic [10:0] dar [192];
  logic [10:0] dai [192];

  initial begin
    model_clear();
    do_reset();

    // Alternating BPSK decisions from bin 0.
    for (int j = 0; j < 128; j++)
      drive(1'b1, (j % 2 == 0) ? 11'd100 : 11'(-100), rnd11(), 1'b0);
    drain();
    check("bpsk_alt_word", last_word[0], {32{4'h5}});

    // 16QAM outer-I / inner-negative-Q, then saturated most-negative I.
    for (int j = 0; j < 64; j++) drive(1'b1, 11'd300, 11'(-50), 1'b0);
    drain();
    check("qam_raw_300_m50", 128'(last_raw[1]), 128'h09);
    for (int j = 0; j < 64; j++) drive(1'b1, 11'h400, 11'd300, 1'b0);
    drain();
    check("qam_raw_sat", 128'(last_raw[1]), 128'h04);

    // Random data, occasional idle cycles and short full pulses.
    for (int j = 0; j < 300; j++)
      drive($urandom_range(0, 4) != 0, rnd11(), rnd11(), $urandom_range(0, 7) == 0);
    drain();

    // Long backpressure with continuous input, then release.
    for (int j = 0; j < 200; j++) drive(1'b1, rnd11(), rnd11(), 1'b1);
    check("bp_ready_low", 128'(rdy[0]), 128'd0);
    check("bp_err_ovf", 128'(eo[0]), 128'd1);
    check("bp_wr_en_low", 128'(wr[0]), 128'd0);
    for (int j = 0; j < 200; j++) drive(1'b1, rnd11(), rnd11(), $urandom_range(0, 3) == 0);
    drain();
    for (int k = 0; k < 3; k++)
      check($sformatf("err_ovf%0d", k), 128'(eo[k]), 128'(err_m[k]));

    // Reset mid-word, then a clean restart must reproduce the first word.
    for (int j = 0; j < 70; j++) drive(1'b1, rnd11(), rnd11(), 1'b0);
    do_reset();
    for (int j = 0; j < 128; j++)
      drive(1'b1, (j % 2 == 0) ? 11'd100 : 11'(-100), rnd11(), 1'b0);
    drain();
    check("restart_word", last_word[0], {32{4'h5}});

    // Same data contiguous and with random gaps must give identical QPSK words.
    for (int j = 0; j < 192; j++) begin
      dar[j] = rnd11();
      dai[j] = rnd11();
    end
    do_reset();
    for (int j = 0; j < 192; j++) drive(1'b1, dar[j], dai[j], 1'b0);
    drain();
    ref_c = got_c;
    do_reset();
    for (int j = 0; j < 192; j++) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, rnd11(), rnd11(), 1'b0);
      drive(1'b1, dar[j], dai[j], 1'b0);
    end
    drain();
    check("gap_word_count", 128'(got_c.size()), 128'(ref_c.size()));
    check("gap_word_count_nonzero", 128'(ref_c.size()), 128'd3);
    for (int j = 0; j < ref_c.size() && j < got_c.size(); j++)
      check($sformatf("gap_word%0d", j), got_c[j], ref_c[j]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
